// File: rtl/range_stream_tx.sv
// FIFO-buffered frame transmitter: buffers pushed words and, on send, streams a
// go/data.../finish frame of the words present at that moment to a range finder.
module range_stream_tx #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     send,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic [WIDTH-1:0]         data_out,
  output logic                     go,
  output logic                     finish,
  output logic                     done,
  output logic                     error
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FIRST,
    S_STREAM,
    S_FINISH
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    r_remain;
  logic             r_full;
  logic             r_busy;
  logic             r_go;
  logic             r_finish;
  logic             r_done;
  logic             r_error;
  logic [WIDTH-1:0] r_data;

  logic             w_wr_acc;
  logic             w_accept;
  logic             w_reject;
  logic             w_pop;
  logic             w_done_nxt;
  logic [CW-1:0]    w_remain_nxt;
  logic [CW-1:0]    w_count_nxt;
  logic [WIDTH-1:0] w_data_nxt;

  // Frame length is latched from the pre-write count, so same-cycle pushes wait for the next frame.
  assign w_wr_acc = wr_en & ~r_full;
  assign w_accept = send & (r_state == S_IDLE) & (r_count != '0);
  assign w_reject = (wr_en & r_full) | (send & ~w_accept);

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Each FIRST/STREAM cycle pops the word shown on data_out and preloads the next one.
  always_comb begin
    w_state_nxt  = r_state;
    w_pop        = 1'b0;
    w_done_nxt   = 1'b0;
    w_remain_nxt = r_remain;
    w_data_nxt   = r_data;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt  = S_FIRST;
          w_remain_nxt = r_count;
          w_data_nxt   = r_mem[r_rd_ptr];
        end
      end
      S_FIRST, S_STREAM: begin
        w_pop        = 1'b1;
        w_remain_nxt = r_remain - CW'(1);
        if (r_remain == CW'(1)) begin
          w_state_nxt = S_FINISH;
        end else begin
          w_state_nxt = S_STREAM;
          w_data_nxt  = r_mem[r_rd_ptr + AW'(1)];
        end
      end
      S_FINISH: begin
        w_state_nxt = S_IDLE;
        w_data_nxt  = '0;
        w_done_nxt  = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_data_nxt  = '0;
      end
    endcase

    w_count_nxt = r_count;
    if (w_wr_acc & ~w_pop)      w_count_nxt = r_count + CW'(1);
    else if (~w_wr_acc & w_pop) w_count_nxt = r_count - CW'(1);
  end

  always_ff @(posedge clock) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_remain <= '0;
      r_full   <= 1'b0;
      r_busy   <= 1'b0;
      r_go     <= 1'b0;
      r_finish <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_data   <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)    r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count  <= w_count_nxt;
      r_remain <= w_remain_nxt;
      r_full   <= (w_count_nxt == CW'(DEPTH));
      r_busy   <= (w_state_nxt != S_IDLE);
      r_go     <= (w_state_nxt == S_FIRST);
      r_finish <= (w_state_nxt == S_FINISH);
      r_done   <= w_done_nxt;
      r_error  <= w_reject;
      r_data   <= w_data_nxt;
    end
  end

  assign full     = r_full;
  assign count    = r_count;
  assign busy     = r_busy;
  assign data_out = r_data;
  assign go       = r_go;
  assign finish   = r_finish;
  assign done     = r_done;
  assign error    = r_error;

endmodule

// File: tb/tb_range_stream_tx.sv
// Bench for range_stream_tx: directed scenarios plus random traffic, checked
// against a queue-and-timeline reference model.
module tb_range_stream_tx;

  localparam int unsigned W     = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam int unsigned VW    = 1 + CW + 1 + W + 4;

  logic          clock;
  logic          reset;
  logic          wr_en;
  logic [W-1:0]  wr_data;
  logic          send;
  logic          full;
  logic [CW-1:0] count;
  logic          busy;
  logic [W-1:0]  data_out;
  logic          go;
  logic          finish;
  logic          done;
  logic          error;
  logic [VW-1:0] dut_vec;

  int total = 0;
  int bad   = 0;

  // Reference model: buffered words, words of the current frame, and the
  // position within the frame timeline (0 = no frame, 1 = go cycle, n+1 =
  // finish cycle, n+2 = done cycle).
  logic [W-1:0] q[$];
  logic [W-1:0] m_fw[$];
  int           m_j   = 0;
  int           m_n   = 0;
  bit           m_err = 1'b0;

  range_stream_tx #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .send     (send),
    .full     (full),
    .count    (count),
    .busy     (busy),
    .data_out (data_out),
    .go       (go),
    .finish   (finish),
    .done     (done),
    .error    (error)
  );

  assign dut_vec = {full, count, busy, data_out, go, finish, done, error};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [VW-1:0] model_vec();
    logic [W-1:0] d;
    logic         bz;
    bz = (m_j >= 1) && (m_j <= m_n + 1);
    d  = '0;
    if (m_j >= 1 && m_j <= m_n)           d = m_fw[m_j-1];
    else if (m_j > 0 && m_j == m_n + 1)   d = m_fw[m_n-1];
    return {q.size() == DEPTH, CW'(q.size()), bz, d, m_j == 1,
            (m_j > 0 && m_j == m_n + 1), (m_j > 0 && m_j == m_n + 2), m_err};
  endfunction

  function automatic void model_step(bit w, logic [W-1:0] d, bit s, bit r);
    bit busy_now;
    bit pop;
    bit acc;
    int sz;
    if (r) begin
      q.delete();
      m_fw.delete();
      m_j   = 0;
      m_n   = 0;
      m_err = 1'b0;
      return;
    end
    sz       = q.size();
    busy_now = (m_j >= 1) && (m_j <= m_n + 1);
    pop      = (m_j >= 1) && (m_j <= m_n);
    acc      = s && !busy_now && (sz > 0);
    m_err    = (w && sz == DEPTH) || (s && !acc);
    if (pop) void'(q.pop_front());
    if (acc) begin
      m_fw = q;
      m_n  = sz;
      m_j  = 1;
    end else if (m_j > 0 && m_j < m_n + 2) begin
      m_j++;
    end else begin
      m_j = 0;
    end
    if (w && sz < DEPTH) q.push_back(d);
  endfunction

  // One clock: apply inputs, advance model at the edge, settle before sampling.
  task automatic cyc(input int w, input int d, input int s, input int r);
    wr_en   = (w != 0);
    wr_data = W'(d);
    send    = (s != 0);
    reset   = (r != 0);
    @(posedge clock);
    model_step(w != 0, W'(d), s != 0, r != 0);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cyc(1, 16'hABCD, 1, 1);
      total++;
      if (dut_vec !== '0) begin
        bad++;
        $display("FAIL reset[%0d]: got %h required 0", i, dut_vec);
      end
    end
  endtask

  task automatic test_frame3();
    logic [W-1:0] seen[$];
    int dn = 0;
    int lo, hi;
    for (int i = 0; i < 10; i++) begin
      case (i)
        0:       cyc(1, 3, 0, 0);
        1:       cyc(1, 9, 0, 0);
        2:       cyc(1, 5, 0, 0);
        3:       cyc(0, 0, 1, 0);
        default: cyc(0, 0, 0, 0);
      endcase
      total++;
      if (dut_vec !== model_vec()) begin
        bad++;
        $display("FAIL frame3[%0d]: got %h required %h", i, dut_vec, model_vec());
      end
      total++;
      if ((go & finish) !== 1'b0) begin
        bad++;
        $display("FAIL frame3_overlap[%0d]: go=%b finish=%b", i, go, finish);
      end
      if (busy && !finish) seen.push_back(data_out);
      if (done) dn++;
    end
    total++;
    if (seen.size() != 3 || seen[0] !== 16'd3 || seen[1] !== 16'd9 || seen[2] !== 16'd5) begin
      bad++;
      $display("FAIL frame3_words: got %0d words required 3,9,5", seen.size());
    end
    lo = 32'hFFFF;
    hi = 0;
    foreach (seen[k]) begin
      if (int'(seen[k]) < lo) lo = int'(seen[k]);
      if (int'(seen[k]) > hi) hi = int'(seen[k]);
    end
    total++;
    if (hi - lo != 6) begin
      bad++;
      $display("FAIL frame3_range: got %0d required 6", hi - lo);
    end
    total++;
    if (dn != 1) begin
      bad++;
      $display("FAIL frame3_done: got %0d pulses required 1", dn);
    end
  endtask

  task automatic test_single();
    for (int i = 0; i < 6; i++) begin
      case (i)
        0:       cyc(1, 7, 0, 0);
        1:       cyc(0, 0, 1, 0);
        default: cyc(0, 0, 0, 0);
      endcase
      total++;
      if (dut_vec !== model_vec()) begin
        bad++;
        $display("FAIL single[%0d]: got %h required %h", i, dut_vec, model_vec());
      end
      total++;
      if ({go, finish, done} !== {i == 1, i == 2, i == 3}) begin
        bad++;
        $display("FAIL single_strobes[%0d]: got %b required %b", i, {go, finish, done},
                 {i == 1, i == 2, i == 3});
      end
      if (i == 2) begin
        total++;
        if (data_out !== 16'd7) begin
          bad++;
          $display("FAIL single_finish_data: got %0d required 7", data_out);
        end
      end
      if (i == 3) begin
        total++;
        if (count !== '0) begin
          bad++;
          $display("FAIL single_count: got %0d required 0", count);
        end
      end
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 23; i++) begin
      if (i < 8)       cyc(1, 16'h100 + i, 0, 0);
      else if (i == 8) cyc(1, 16'hDEAD, 0, 0);
      else if (i == 9) cyc(0, 0, 1, 0);
      else             cyc(0, 0, 0, 0);
      total++;
      if (dut_vec !== model_vec()) begin
        bad++;
        $display("FAIL full[%0d]: got %h required %h", i, dut_vec, model_vec());
      end
      if (i == 7 || i == 8) begin
        total++;
        if ({full, count, error} !== {1'b1, CW'(8), i == 8}) begin
          bad++;
          $display("FAIL full_flags[%0d]: full=%b count=%0d error=%b required 1/8/%0d",
                   i, full, count, error, i == 8);
        end
      end
      if (busy) begin
        total++;
        if (data_out === 16'hDEAD) begin
          bad++;
          $display("FAIL full_dropped_sent[%0d]: got %h required not DEAD", i, data_out);
        end
      end
    end
  endtask

  task automatic test_errors();
    for (int i = 0; i < 10; i++) begin
      case (i)
        0:       cyc(0, 0, 1, 0);
        1:       cyc(1, 16'h11, 0, 0);
        2:       cyc(1, 16'h22, 0, 0);
        3:       cyc(0, 0, 1, 0);
        4:       cyc(0, 0, 1, 0);
        default: cyc(0, 0, 0, 0);
      endcase
      total++;
      if (dut_vec !== model_vec()) begin
        bad++;
        $display("FAIL errors[%0d]: got %h required %h", i, dut_vec, model_vec());
      end
      if (i == 0) begin
        total++;
        if ({error, busy, go} !== 3'b100) begin
          bad++;
          $display("FAIL err_empty: got %b required 100", {error, busy, go});
        end
      end
      if (i == 4) begin
        total++;
        if ({error, busy, data_out} !== {2'b11, 16'h22}) begin
          bad++;
          $display("FAIL err_busy: got %b %b %h required 1 1 0022", error, busy, data_out);
        end
      end
    end
  endtask

  task automatic test_midframe();
    for (int i = 0; i < 13; i++) begin
      case (i)
        0:       cyc(1, 1, 0, 0);
        1:       cyc(1, 2, 0, 0);
        2:       cyc(0, 0, 1, 0);
        3:       cyc(1, 4, 0, 0);
        6:       cyc(1, 5, 0, 0);
        7:       cyc(0, 0, 1, 0);
        8:       cyc(0, 0, 0, 1);
        default: cyc(0, 0, 0, 0);
      endcase
      total++;
      if (dut_vec !== model_vec()) begin
        bad++;
        $display("FAIL midframe[%0d]: got %h required %h", i, dut_vec, model_vec());
      end
      if (i == 4) begin
        total++;
        if ({finish, data_out} !== {1'b1, 16'd2}) begin
          bad++;
          $display("FAIL mid_last_word: got %b %0d required 1 2", finish, data_out);
        end
      end
      if (i == 5) begin
        total++;
        if ({done, count} !== {1'b1, CW'(1)}) begin
          bad++;
          $display("FAIL mid_count: got done=%b count=%0d required 1 1", done, count);
        end
      end
      if (i >= 8) begin
        total++;
        if ({finish, done, busy, count} !== '0) begin
          bad++;
          $display("FAIL mid_reset[%0d]: got finish=%b done=%b busy=%b count=%0d required 0",
                   i, finish, done, busy, count);
        end
      end
    end
  endtask

  task automatic test_random();
    int w, s, r;
    for (int i = 0; i < 800; i++) begin
      w = int'($urandom_range(0, 99) < 55);
      s = int'($urandom_range(0, 9) == 0);
      r = int'($urandom_range(0, 199) == 0);
      cyc(w, int'($urandom), s, r);
      total++;
      if (dut_vec !== model_vec()) begin
        bad++;
        $display("FAIL random[%0d]: got %h required %h", i, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      case (i)
        0, 1:    cyc(1, 16'h40 + i, 0, 0);
        2:       cyc(1, 16'h50, 1, 0);
        5:       cyc(0, 0, 1, 0);
        default: cyc(0, 0, 0, 0);
      endcase
      total++;
      if (dut_vec !== model_vec()) begin
        bad++;
        $display("FAIL back_to_back[%0d]: got %h required %h", i, dut_vec, model_vec());
      end
    end
  endtask

  initial begin
    wr_en   = 1'b0;
    wr_data = '0;
    send    = 1'b0;
    reset   = 1'b1;
    test_reset();
    test_frame3();
    test_single();
    test_full();
    test_errors();
    test_midframe();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
